// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Scans a 4-digit common-anode seven-segment display through one shared
// BCD decoder. Each digit slot opens with a dead-time window where every
// anode is off. The decoder nibble is loaded at the slot start, so it has
// settled before the anode turns on. Host writes go into a shadow register
// and are committed only at the frame boundary, so a frame never shows a
// mix of old and new digits.

module seg7_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    localparam int              CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    // Slot sequencing state
    phase_t           phase, phase_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       dig, dig_next;

    // Display and host-update buffering state
    logic [15:0]      disp, disp_next;
    logic [15:0]      shadow, shadow_next;
    logic             pending_next;
    logic             frame_tick_next;

    // Per-slot output state
    logic [3:0]       bcd_next;
    logic             slot_blank, slot_blank_next;
    logic [3:0]       an_next;

    logic             slot_end;
    logic             frame_end;

    // Selects nibble k of a packed 4-digit BCD word.
    function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] k);
        logic [3:0] n;
        case (k)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    // True when digit k and every digit above it are zero. Digit 0 always
    // reports false so a zero value still lights the rightmost digit.
    function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] k);
        logic z;
        case (k)
            2'd1:    z = (v[15:4]  == 12'h000);
            2'd2:    z = (v[15:8]  == 8'h00);
            2'd3:    z = (v[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (dig == 2'd3);

    // Slot FSM: dead-time phase, then on phase, then advance to the next digit.
    always_comb begin
        cnt_next   = cnt + 1'b1;
        dig_next   = dig;
        phase_next = phase;
        case (phase)
            PH_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    phase_next = PH_ON;
                end
            end
            PH_ON: begin
                if (slot_end) begin
                    cnt_next   = '0;
                    dig_next   = dig + 2'd1;
                    phase_next = PH_BLANK;
                end
            end
            default: begin
                phase_next = PH_BLANK;
            end
        endcase
    end

    // Host updates: the latest write lands in shadow and is committed to disp
    // at the frame boundary; a write on the boundary edge itself bypasses shadow.
    always_comb begin
        disp_next       = disp;
        shadow_next     = shadow;
        pending_next    = pending;
        frame_tick_next = frame_end;
        if (frame_end) begin
            if (load) begin
                disp_next   = value;
                shadow_next = value;
            end else if (pending) begin
                disp_next = shadow;
            end
            pending_next = 1'b0;
        end else if (load) begin
            shadow_next  = value;
            pending_next = 1'b1;
        end
    end

    // Slot-start decode: pick the next nibble and decide, once per slot,
    // whether this digit stays dark (invalid BCD or a leading zero).
    always_comb begin
        bcd_next        = bcd_out;
        slot_blank_next = slot_blank;
        if (slot_end) begin
            bcd_next        = nibble_of(disp_next, dig_next);
            slot_blank_next = (bcd_next > 4'd9) ||
                              (lz_blank && upper_zero(disp_next, dig_next));
        end
    end

    // Anode drive for the coming cycle: at most one low bit, and only in the on phase.
    always_comb begin
        an_next = 4'b1111;
        if ((phase_next == PH_ON) && !slot_blank_next) begin
            an_next = ~(4'b0001 << dig_next);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_BLANK;
            cnt        <= '0;
            dig        <= 2'd0;
            disp       <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            bcd_out    <= 4'h0;
            slot_blank <= 1'b0;
            an         <= 4'b1111;
        end else begin
            phase      <= phase_next;
            cnt        <= cnt_next;
            dig        <= dig_next;
            disp       <= disp_next;
            shadow     <= shadow_next;
            pending    <= pending_next;
            frame_tick <= frame_tick_next;
            bcd_out    <= bcd_next;
            slot_blank <= slot_blank_next;
            an         <= an_next;
        end
    end

endmodule
